// File: rtl/matrix_frame_blitter_if.sv
// Classic Wishbone byte-bus bundle used by the frame blitter (master) and its bus slave.
interface matrix_frame_blitter_if #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 8
);
  logic [ADDRESS_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0]    dat_o;
  logic [DATA_WIDTH-1:0]    dat_i;
  logic                     we_o;
  logic                     sel_o;
  logic                     stb_o;
  logic                     cyc_o;
  logic                     ack_i;
  logic [2:0]               cti_o;

  modport master (
    output adr_o, dat_o, we_o, sel_o, stb_o, cyc_o, cti_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, sel_o, stb_o, cyc_o, cti_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/matrix_frame_blitter.sv
// Wishbone master that copies or fills a byte run into the LED matrix frame window,
// optionally synchronised to the end-of-frame pulse, with per-access ack timeout.
module matrix_frame_blitter #(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  input  logic                     mode_i,
  input  logic                     sync_i,
  input  logic                     abort_i,
  input  logic [ADDRESS_WIDTH-1:0] src_adr_i,
  input  logic [ADDRESS_WIDTH-1:0] dst_adr_i,
  input  logic [ADDRESS_WIDTH-1:0] len_i,
  input  logic [DATA_WIDTH-1:0]    fill_i,
  input  logic                     frame_complete_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  matrix_frame_blitter_if.master   wb
);

  localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] AdrOne = ADDRESS_WIDTH'(1);
  localparam logic [TmoWidth-1:0] TmoOne = TmoWidth'(1);

  typedef enum logic [2:0] {StIdle, StSync, StRd, StWr, StGap, StDone} state_e;

  state_e state_q, state_d;

  logic [ADDRESS_WIDTH-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d, idx_q, idx_d, idx_inc;
  logic [DATA_WIDTH-1:0]    fill_q, fill_d, byte_q, byte_d;
  logic                     mode_q, mode_d, gap_rd_q, gap_rd_d;
  logic [TmoWidth-1:0]      tmo_q, tmo_d;
  logic                     in_bus, acked, timeout;

  logic                     cyc_q, cyc_d, we_q, we_d, sel_q, sel_d;
  logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0]    dat_q, dat_d;
  logic                     busy_q, busy_d, done_q, done_d, err_q, err_d;

  assign in_bus  = (state_q == StRd) || (state_q == StWr);
  // abort wins over a coincident ack
  assign acked   = in_bus && wb.ack_i && !abort_i;
  assign timeout = in_bus && !wb.ack_i && !abort_i && (tmo_q == TmoLast);
  assign idx_inc = idx_q + AdrOne;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_i == '0) begin
            state_d = StDone;
          end else if (sync_i) begin
            state_d = StSync;
          end else begin
            state_d = mode_i ? StWr : StRd;
          end
        end
      end
      StSync: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (frame_complete_i) begin
          state_d = mode_q ? StWr : StRd;
        end
      end
      StRd: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (acked) begin
          state_d = StGap;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StWr: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (acked) begin
          state_d = (idx_inc == len_q) ? StDone : StGap;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StGap: begin
        if (abort_i) begin
          state_d = StIdle;
        end else begin
          state_d = gap_rd_q ? StRd : StWr;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Job parameters, byte index, captured read byte and ack timer
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    fill_d   = fill_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    gap_rd_d = gap_rd_q;
    // restarts whenever the strobe is low, so it counts from each stb rise
    tmo_d    = in_bus ? tmo_q + TmoOne : '0;
    if (state_q == StIdle && start_i) begin
      src_d  = src_adr_i;
      dst_d  = dst_adr_i;
      len_d  = len_i;
      fill_d = fill_i;
      mode_d = mode_i;
      idx_d  = '0;
    end
    if (state_q == StRd && acked) begin
      byte_d   = wb.dat_i;
      gap_rd_d = 1'b0;
    end
    if (state_q == StWr && acked) begin
      idx_d    = idx_inc;
      gap_rd_d = !mode_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      mode_q   <= 1'b0;
      idx_q    <= '0;
      byte_q   <= '0;
      gap_rd_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      gap_rd_q <= gap_rd_d;
      tmo_q    <= tmo_d;
    end
  end

  // Output logic: bus and status outputs are registered from the next state
  always_comb begin
    cyc_d  = (state_d == StRd) || (state_d == StWr);
    we_d   = (state_d == StWr);
    sel_d  = 1'b1;
    adr_d  = adr_q;
    dat_d  = dat_q;
    busy_d = (state_d == StSync) || (state_d == StRd) || (state_d == StWr) ||
             (state_d == StGap);
    done_d = (state_d == StDone);
    err_d  = timeout;
    if (state_d == StRd) begin
      adr_d = src_d + idx_d;
    end else if (state_d == StWr) begin
      adr_d = dst_d + idx_d;
      dat_d = mode_d ? fill_d : byte_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cyc_q  <= cyc_d;
      we_q   <= we_d;
      sel_q  <= sel_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign wb.cyc_o = cyc_q;
  assign wb.stb_o = cyc_q;
  assign wb.we_o  = we_q;
  assign wb.sel_o = sel_q;
  assign wb.adr_o = adr_q;
  assign wb.dat_o = dat_q;
  assign wb.cti_o = 3'b000;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_matrix_frame_blitter.sv
// Scoreboard bench for matrix_frame_blitter: a Wishbone slave model with programmable ack
// latency, expected bus transfers and job completions queued by the stimulus.
module tb_matrix_frame_blitter;

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [7:0]  dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, sync, abort, frame_complete;
  logic [15:0] src, dst, len;
  logic [7:0]  fill;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int done_cnt = 0;
  int cyc_cnt = 0;
  int wr_cnt = 0;
  int stb_rise_t = 0;
  int done_t = 0;
  logic busy_at_done = 1'b0;
  logic xfer, xfer_prev, stb_prev;
  txn_t t;

  txn_t exp_q[$];
  logic exp_done_q[$];
  logic sb_on;

  int   ack_delay;
  logic no_ack;
  int   wait_cnt;
  logic [7:0] src_mem [0:65535];
  logic [7:0] dst_mem [0:65535];

  matrix_frame_blitter_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) wb ();

  matrix_frame_blitter #(
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (start),
    .mode_i          (mode),
    .sync_i          (sync),
    .abort_i         (abort),
    .src_adr_i       (src),
    .dst_adr_i       (dst),
    .len_i           (len),
    .fill_i          (fill),
    .frame_complete_i(frame_complete),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .wb              (wb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Slave: acks ack_delay cycles after stb is seen, holds ack while cyc stays high
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.ack_i <= 1'b0;
      wb.dat_i <= 8'h00;
      wait_cnt <= 0;
    end else if (!wb.cyc_o) begin
      wb.ack_i <= 1'b0;
      wait_cnt <= 0;
    end else if (!wb.ack_i && wb.stb_o && !no_ack) begin
      if (wait_cnt >= ack_delay) begin
        wb.ack_i <= 1'b1;
        wait_cnt <= 0;
        if (wb.we_o) dst_mem[wb.adr_o] <= wb.dat_o;
        else         wb.dat_i <= src_mem[wb.adr_o];
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every acked transfer and every done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb.cyc_o) cyc_cnt++;
      if (xfer_prev) check("cyc_drop_after_ack", 32'(wb.cyc_o), 32'd0);
      xfer = wb.cyc_o && wb.stb_o && wb.ack_i;
      if (xfer && wb.we_o) wr_cnt++;
      if (xfer && sb_on) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", {15'd0, wb.we_o, wb.adr_o}, 32'hFFFF_FFFF);
        end else begin
          t = exp_q.pop_front();
          check("xfer_we", 32'(wb.we_o), 32'(t.we));
          check("xfer_adr", 32'(wb.adr_o), 32'(t.adr));
          if (t.we) check("xfer_dat", 32'(wb.dat_o), 32'(t.dat));
          check("xfer_sel", 32'(wb.sel_o), 32'd1);
          check("xfer_cti", 32'(wb.cti_o), 32'd0);
        end
      end
      if (wb.stb_o && !stb_prev) stb_rise_t = cycle;
      if (done) begin
        done_t       = cycle;
        busy_at_done = busy;
        done_cnt++;
        if (exp_done_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("done_err", 32'(err), 32'(exp_done_q.pop_front()));
      end else begin
        check("err_only_with_done", 32'(err), 32'd0);
      end
      xfer_prev = xfer;
      stb_prev  = wb.stb_o;
    end else begin
      xfer_prev = 1'b0;
      stb_prev  = 1'b0;
    end
  end

  task automatic push_txn(input logic w, input logic [15:0] a, input logic [7:0] d);
    txn_t n;
    n.we  = w;
    n.adr = a;
    n.dat = d;
    exp_q.push_back(n);
  endtask

  task automatic start_job(input logic m, input logic s, input logic [15:0] sa,
                           input logic [15:0] da, input logic [15:0] ln, input logic [7:0] fb);
    mode  = m;
    sync  = s;
    src   = sa;
    dst   = da;
    len   = ln;
    fill  = fb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completes"}, 32'(done_cnt >= target), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int snap;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; sync = 1'b0; abort = 1'b0;
    frame_complete = 1'b0; src = '0; dst = '0; len = '0; fill = '0;
    sb_on = 1'b1; ack_delay = 0; no_ack = 1'b0;
    src_mem[16'h0100] = 8'h11;
    src_mem[16'h0101] = 8'h22;
    src_mem[16'h0102] = 8'h33;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(wb.cyc_o), 0);
    check("rst_stb", 32'(wb.stb_o), 0);
    check("rst_we", 32'(wb.we_o), 0);
    check("rst_sel", 32'(wb.sel_o), 0);
    check("rst_adr", 32'(wb.adr_o), 0);
    check("rst_dat", 32'(wb.dat_o), 0);
    check("rst_cti", 32'(wb.cti_o), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Fill 4 x 0xA5 into 0x8000
    for (int i = 0; i < 4; i++) push_txn(1'b1, 16'h8000 + 16'(i), 8'hA5);
    exp_done_q.push_back(1'b0);
    start_job(1'b1, 1'b0, 16'h0000, 16'h8000, 16'd4, 8'hA5);
    wait_done(1, 100, "fill");
    check("fill_queue_empty", 32'(exp_q.size()), 0);
    for (int i = 0; i < 4; i++) check("fill_mem", 32'(dst_mem[16'h8000 + 16'(i)]), 32'hA5);

    // Copy 11,22,33 from 0x0100 to 0x8010: reads and writes alternate
    push_txn(1'b0, 16'h0100, 8'h00); push_txn(1'b1, 16'h8010, 8'h11);
    push_txn(1'b0, 16'h0101, 8'h00); push_txn(1'b1, 16'h8011, 8'h22);
    push_txn(1'b0, 16'h0102, 8'h00); push_txn(1'b1, 16'h8012, 8'h33);
    exp_done_q.push_back(1'b0);
    start_job(1'b0, 1'b0, 16'h0100, 16'h8010, 16'd3, 8'h00);
    wait_done(2, 100, "copy");
    check("copy_queue_empty", 32'(exp_q.size()), 0);
    check("copy_mem0", 32'(dst_mem[16'h8010]), 32'h11);
    check("copy_mem2", 32'(dst_mem[16'h8012]), 32'h33);

    // Zero length: done the next cycle, no bus cycle
    snap = cyc_cnt;
    exp_done_q.push_back(1'b0);
    start_job(1'b1, 1'b0, 16'h0000, 16'h8000, 16'd0, 8'hEE);
    check("len0_done_next_cycle", 32'(done), 1);
    repeat (5) @(posedge clk);
    #1;
    check("len0_no_cyc", 32'(cyc_cnt - snap), 0);
    check("len0_done_count", 32'(done_cnt), 3);

    // Stalled ack (5 cycles) plus an ignored start while busy
    ack_delay = 5;
    for (int i = 0; i < 3; i++) push_txn(1'b1, 16'h8020 + 16'(i), 8'h3C);
    exp_done_q.push_back(1'b0);
    start_job(1'b1, 1'b0, 16'h0000, 16'h8020, 16'd3, 8'h3C);
    repeat (4) @(posedge clk);
    #1;
    start_job(1'b1, 1'b0, 16'h0000, 16'h9000, 16'd2, 8'hFF);
    wait_done(4, 200, "stall");
    check("stall_queue_empty", 32'(exp_q.size()), 0);
    check("ignored_start_no_write", 32'(dst_mem[16'h9000] === 8'hFF), 0);
    ack_delay = 0;

    // Sync: nothing on the bus until frame_complete
    for (int i = 0; i < 2; i++) push_txn(1'b1, 16'h8030 + 16'(i), 8'h5A);
    exp_done_q.push_back(1'b0);
    snap = cyc_cnt;
    start_job(1'b1, 1'b1, 16'h0000, 16'h8030, 16'd2, 8'h5A);
    repeat (20) @(posedge clk);
    #1;
    check("sync_no_cyc", 32'(cyc_cnt - snap), 0);
    check("sync_busy", 32'(busy), 1);
    frame_complete = 1'b1;
    @(posedge clk);
    #1 frame_complete = 1'b0;
    wait_done(5, 100, "sync");
    check("sync_queue_empty", 32'(exp_q.size()), 0);

    // Timeout: ack never returns
    no_ack = 1'b1;
    exp_done_q.push_back(1'b1);
    start_job(1'b1, 1'b0, 16'h0000, 16'h8040, 16'd2, 8'h77);
    wait_done(6, 100, "timeout");
    check("timeout_latency", 32'(done_t - stb_rise_t), 8);
    check("timeout_busy_at_done", 32'(busy_at_done), 0);
    check("timeout_cyc_low", 32'(wb.cyc_o), 0);
    check("timeout_no_write", 32'(dst_mem[16'h8040] === 8'h77), 0);
    no_ack = 1'b0;

    // Abort mid-fill: idle, no done
    sb_on = 1'b0;
    snap = wr_cnt;
    start_job(1'b1, 1'b0, 16'h0000, 16'h8100, 16'd100, 8'hEE);
    n = 0;
    while (wr_cnt - snap < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_fill_started", 32'(wr_cnt - snap >= 2), 1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_cyc_low", 32'(wb.cyc_o), 0);
    check("abort_busy_low", 32'(busy), 0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 6);
    check("abort_stays_idle", 32'(wb.cyc_o), 0);

    // Reset mid-copy: bus drops at once
    ack_delay = 5;
    start_job(1'b0, 1'b0, 16'h0100, 16'h8200, 16'd3, 8'h00);
    n = 0;
    while (!wb.cyc_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reset_copy_started", 32'(wb.cyc_o), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_cyc_async", 32'(wb.cyc_o), 0);
    check("reset_stb_async", 32'(wb.stb_o), 0);
    check("reset_busy_async", 32'(busy), 0);
    check("reset_adr_async", 32'(wb.adr_o), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_job_lost_busy", 32'(busy), 0);
    check("reset_job_lost_cyc", 32'(wb.cyc_o), 0);
    check("reset_no_done", 32'(done_cnt), 6);
    check("done_queue_empty", 32'(exp_done_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
